mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter Store_Burst, default 4, max consecutive store grants while another requester is pending.
REQ-002 Clock and reset: one clock and one reset; reset is synchronous and active-high.
REQ-003 clk  in  1  system clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 if_req  in  1  instruction-fetch request, held until if_done or flush.
REQ-006 if_addr  in  `Inst_Addr_Width  fetch address, stable while if_req high.
REQ-007 if_done  out  1  one-cycle pulse: if_data valid.
REQ-008 if_data  out  `Inst_Width  fetched word.
REQ-009 ld_req  in  1  load read request from LoadStore side.
REQ-010 ld_addr  in  `Addr_Width  load address.
REQ-011 ld_done  out  1  one-cycle pulse: ld_data valid.
REQ-012 ld_data  out  `Data_Width  loaded word.
REQ-013 st_req  in  1  committed store from ROB.
REQ-014 st_addr / st_data / st_mask  in  `Addr_Width / `Data_Width / 4  store address, data, byte mask.
REQ-015 st_done  out  1  one-cycle pulse: store written.
REQ-016 flush  in  1  misprediction flush; cancels fetch only.
REQ-017 mem_req  out  1  memory port request, held until mem_ready.
REQ-018 mem_we / mem_mask  out  1 / 4  write enable, byte mask (mask 0 on reads).
REQ-019 mem_addr / mem_wdata  out  `Addr_Width / `Data_Width  registered port address and write data.
REQ-020 mem_ready / mem_rdata  in  1 / `Data_Width  memory completion and read data, same cycle.

Function
REQ-021 FSM states SHALL be IDLE, BUSY, RESP; IDLE->BUSY on any grant, BUSY->RESP on mem_ready sampled high, RESP->IDLE always.
REQ-022 In IDLE arbiter SHALL grant one requester, register its address/data/mask and owner id into mem_* registers.
REQ-023 Priority SHALL be store first; load and fetch then alternate round-robin (pointer flips to the other after each load/fetch grant).
REQ-024 Store counter SHALL increment per store grant, clear on any non-store grant; at Store_Burst with ld_req or if_req pending, store SHALL be skipped for one grant.
REQ-025 mem_req SHALL be high exactly in BUSY; mem_we=1 only for store owner.
REQ-026 In BUSY, mem_rdata SHALL be captured into if_data or ld_data at the edge where mem_ready is high.
REQ-027 In RESP exactly one of if_done/ld_done/st_done SHALL be high, matching owner; all done pulses low elsewhere.
REQ-028 Minimum latency: req seen in IDLE cycle N, done high in cycle N+2 when mem_ready is high in the first BUSY cycle; each extra stall cycle adds one.
REQ-029 Requesters SHALL drop req at the edge ending RESP; IDLE therefore never regrants a completed request.
REQ-030 flush in IDLE SHALL mask if_req that cycle; flush in BUSY/RESP with fetch owner SHALL let memory complete but suppress if_done.
REQ-031 Simultaneous flush and store/load grant SHALL be unaffected.
REQ-032 No requests in IDLE: remain IDLE, mem_req 0, counters unchanged.

Reset
REQ-033 rst SHALL force IDLE, all done pulses 0, mem_req 0, mem_we 0, mem_mask 0, mem_addr/mem_wdata/if_data/ld_data 0, store counter 0, RR pointer to load.
REQ-034 Reset mid-BUSY SHALL abort: mem_req low the next cycle, no done pulse for the aborted owner.

Structure
REQ-035 `Addr_Width, `Data_Width, `Inst_Width, `Inst_Addr_Width, `Arb_Store_Burst and the 2-bit state and owner encodings SHALL live in defines.v.
REQ-036 Single module, no sub-module; grant logic is combinational inside, all outputs registered.

Verification
REQ-037 Load only, ld_addr=0x100, memory returns 0xDEADBEEF with 0 stall -> mem_req cycle 1, ld_done and ld_data=0xDEADBEEF in cycle 2.
REQ-038 if_req and ld_req together from reset -> load granted first, then fetch; alternating thereafter.
REQ-039 st_req held with 6 back-to-back stores plus ld_req pending, Store_Burst=4 -> 4 st_done, then ld_done, then remaining 2 stores.
REQ-040 Fetch in BUSY with 3 stall cycles, flush pulsed in the 2nd -> mem_req held 3 cycles, no if_done, next IDLE grants normally.
REQ-041 Store mask 0b0011, data 0x12345678 -> mem_we=1, mem_mask=0011, mem_wdata=0x12345678 throughout BUSY, st_done once.
REQ-042 rst asserted in BUSY of a load -> next cycle IDLE, mem_req 0, ld_done never asserted.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared widths, burst default and the state/owner encodings for the
// memory-port arbiter.
package mem_arbiter_pkg;

    localparam int ADDR_WIDTH      = 32;
    localparam int DATA_WIDTH      = 32;
    localparam int INST_WIDTH      = 32;
    localparam int INST_ADDR_WIDTH = 32;
    localparam int ARB_STORE_BURST = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } arbState_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_LD   = 2'd2,
        OWN_ST   = 2'd3
    } owner_t;

endpackage

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter shared by instruction fetch, loads and committed
// stores; one transaction in flight, all outputs registered.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int Store_Burst = ARB_STORE_BURST
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       if_req,
    input  logic [INST_ADDR_WIDTH-1:0] if_addr,
    output logic                       if_done,
    output logic [INST_WIDTH-1:0]      if_data,
    input  logic                       ld_req,
    input  logic [ADDR_WIDTH-1:0]      ld_addr,
    output logic                       ld_done,
    output logic [DATA_WIDTH-1:0]      ld_data,
    input  logic                       st_req,
    input  logic [ADDR_WIDTH-1:0]      st_addr,
    input  logic [DATA_WIDTH-1:0]      st_data,
    input  logic [3:0]                 st_mask,
    output logic                       st_done,
    input  logic                       flush,
    output logic                       mem_req,
    output logic                       mem_we,
    output logic [3:0]                 mem_mask,
    output logic [ADDR_WIDTH-1:0]      mem_addr,
    output logic [DATA_WIDTH-1:0]      mem_wdata,
    input  logic                       mem_ready,
    input  logic [DATA_WIDTH-1:0]      mem_rdata
);

    localparam int CntWidth = $clog2(Store_Burst + 1);
    localparam logic [CntWidth-1:0] BurstMax = CntWidth'(Store_Burst);

    arbState_t             state_q;
    owner_t                owner_q;
    owner_t                grant_d;
    logic [CntWidth-1:0]   stCnt_q;
    logic                  rrFetch_q;
    logic                  fetchKilled_q;
    logic                  memReq_q;
    logic                  memWe_q;
    logic [3:0]            memMask_q;
    logic [ADDR_WIDTH-1:0] memAddr_q;
    logic [DATA_WIDTH-1:0] memWdata_q;
    logic                  ifDone_q;
    logic                  ldDone_q;
    logic                  stDone_q;
    logic [INST_WIDTH-1:0] ifData_q;
    logic [DATA_WIDTH-1:0] ldData_q;
    logic                  ifPending;
    logic                  burstHit;

    // Stores win unless they have used up their burst while a read waits;
    // loads and fetches share the remaining slots round-robin.
    always_comb begin
        grant_d   = OWN_NONE;
        ifPending = if_req && !flush;
        burstHit  = (stCnt_q == BurstMax) && (ld_req || ifPending);
        if (st_req && !burstHit) begin
            grant_d = OWN_ST;
        end else if (ld_req && ifPending) begin
            grant_d = rrFetch_q ? OWN_IF : OWN_LD;
        end else if (ld_req) begin
            grant_d = OWN_LD;
        end else if (ifPending) begin
            grant_d = OWN_IF;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            owner_q       <= OWN_NONE;
            stCnt_q       <= '0;
            rrFetch_q     <= 1'b0;
            fetchKilled_q <= 1'b0;
            memReq_q      <= 1'b0;
            memWe_q       <= 1'b0;
            memMask_q     <= '0;
            memAddr_q     <= '0;
            memWdata_q    <= '0;
            ifDone_q      <= 1'b0;
            ldDone_q      <= 1'b0;
            stDone_q      <= 1'b0;
            ifData_q      <= '0;
            ldData_q      <= '0;
        end else begin
            ifDone_q <= 1'b0;
            ldDone_q <= 1'b0;
            stDone_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grant_d != OWN_NONE) begin
                        state_q       <= ST_BUSY;
                        owner_q       <= grant_d;
                        memReq_q      <= 1'b1;
                        fetchKilled_q <= 1'b0;
                        case (grant_d)
                            OWN_ST: begin
                                memWe_q    <= 1'b1;
                                memMask_q  <= st_mask;
                                memAddr_q  <= st_addr;
                                memWdata_q <= st_data;
                                if (stCnt_q != BurstMax) begin
                                    stCnt_q <= stCnt_q + 1'b1;
                                end
                            end
                            OWN_LD: begin
                                memWe_q    <= 1'b0;
                                memMask_q  <= '0;
                                memAddr_q  <= ld_addr;
                                memWdata_q <= '0;
                                stCnt_q    <= '0;
                                rrFetch_q  <= 1'b1;
                            end
                            OWN_IF: begin
                                memWe_q    <= 1'b0;
                                memMask_q  <= '0;
                                memAddr_q  <= ADDR_WIDTH'(if_addr);
                                memWdata_q <= '0;
                                stCnt_q    <= '0;
                                rrFetch_q  <= 1'b0;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_BUSY: begin
                    // A flushed fetch still finishes on the port; only its done pulse is dropped.
                    if (flush && owner_q == OWN_IF) begin
                        fetchKilled_q <= 1'b1;
                    end
                    if (mem_ready) begin
                        state_q   <= ST_RESP;
                        memReq_q  <= 1'b0;
                        memWe_q   <= 1'b0;
                        memMask_q <= '0;
                        case (owner_q)
                            OWN_IF: begin
                                ifData_q <= INST_WIDTH'(mem_rdata);
                                ifDone_q <= !(fetchKilled_q || flush);
                            end
                            OWN_LD: begin
                                ldData_q <= mem_rdata;
                                ldDone_q <= 1'b1;
                            end
                            OWN_ST: stDone_q <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                ST_RESP: begin
                    state_q <= ST_IDLE;
                    owner_q <= OWN_NONE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign mem_req   = memReq_q;
    assign mem_we    = memWe_q;
    assign mem_mask  = memMask_q;
    assign mem_addr  = memAddr_q;
    assign mem_wdata = memWdata_q;
    assign if_done   = ifDone_q;
    assign if_data   = ifData_q;
    assign ld_done   = ldDone_q;
    assign ld_data   = ldData_q;
    assign st_done   = stDone_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter: each step drives inputs,
// advances one clock and compares outputs against hand-computed values.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       if_req;
    logic [INST_ADDR_WIDTH-1:0] if_addr;
    logic                       if_done;
    logic [INST_WIDTH-1:0]      if_data;
    logic                       ld_req;
    logic [ADDR_WIDTH-1:0]      ld_addr;
    logic                       ld_done;
    logic [DATA_WIDTH-1:0]      ld_data;
    logic                       st_req;
    logic [ADDR_WIDTH-1:0]      st_addr;
    logic [DATA_WIDTH-1:0]      st_data;
    logic [3:0]                 st_mask;
    logic                       st_done;
    logic                       flush;
    logic                       mem_req;
    logic                       mem_we;
    logic [3:0]                 mem_mask;
    logic [ADDR_WIDTH-1:0]      mem_addr;
    logic [DATA_WIDTH-1:0]      mem_wdata;
    logic                       mem_ready;
    logic [DATA_WIDTH-1:0]      mem_rdata;

    int checkCount = 0;
    int passCount  = 0;

    mem_arbiter #(.Store_Burst(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_done   (if_done),
        .if_data   (if_data),
        .ld_req    (ld_req),
        .ld_addr   (ld_addr),
        .ld_done   (ld_done),
        .ld_data   (ld_data),
        .st_req    (st_req),
        .st_addr   (st_addr),
        .st_data   (st_data),
        .st_mask   (st_mask),
        .st_done   (st_done),
        .flush     (flush),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_mask  (mem_mask),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: observed timeout expected finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    endtask

    task automatic applyStimulus(input logic ifReq, input logic ldReq,
                                 input logic stReq, input logic ready);
        if_req    = ifReq;
        ld_req    = ldReq;
        st_req    = stReq;
        mem_ready = ready;
    endtask

    // Outputs are observed 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        flush = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [6:0] loadSlot;
        int storesDone;
        if_addr   = '0;
        ld_addr   = '0;
        st_addr   = '0;
        st_data   = '0;
        st_mask   = '0;
        mem_rdata = '0;
        doReset();

        checkOutput("rst mem_req", mem_req, 0);
        checkOutput("rst mem_we", mem_we, 0);
        checkOutput("rst mem_mask", mem_mask, 0);
        checkOutput("rst mem_addr", mem_addr, 0);
        checkOutput("rst mem_wdata", mem_wdata, 0);
        checkOutput("rst if_data", if_data, 0);
        checkOutput("rst ld_data", ld_data, 0);
        checkOutput("rst dones", {29'd0, if_done, ld_done, st_done}, 0);

        tick();
        checkOutput("idle no req", mem_req, 0);

        // Single zero-stall load
        ld_addr = 32'h100;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("ld busy mem_req", mem_req, 1);
        checkOutput("ld busy mem_addr", mem_addr, 32'h100);
        checkOutput("ld busy mem_we", mem_we, 0);
        checkOutput("ld busy ld_done", ld_done, 0);
        mem_rdata = 32'hDEADBEEF;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        checkOutput("ld resp ld_done", ld_done, 1);
        checkOutput("ld resp ld_data", ld_data, 32'hDEADBEEF);
        checkOutput("ld resp mem_req", mem_req, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("ld idle ld_done", ld_done, 0);

        // Load and fetch together from reset: load first, then fetch, then load
        doReset();
        if_addr = 32'h40;
        ld_addr = 32'h200;
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("rr grant1 addr", mem_addr, 32'h200);
        mem_rdata = 32'h11111111;
        mem_ready = 1'b1;
        tick();
        checkOutput("rr grant1 ld_done", ld_done, 1);
        ld_addr   = 32'h204;
        mem_ready = 1'b0;
        tick();
        tick();
        checkOutput("rr grant2 addr", mem_addr, 32'h40);
        mem_rdata = 32'h22222222;
        mem_ready = 1'b1;
        tick();
        checkOutput("rr grant2 if_done", if_done, 1);
        checkOutput("rr grant2 if_data", if_data, 32'h22222222);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        checkOutput("rr grant3 addr", mem_addr, 32'h204);
        mem_ready = 1'b1;
        tick();
        checkOutput("rr grant3 ld_done", ld_done, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Six stores with a load waiting: the load takes the fifth slot
        doReset();
        st_addr = 32'h300;
        st_data = 32'hCAFE0000;
        st_mask = 4'hF;
        ld_addr = 32'h400;
        loadSlot = 7'b0010000;
        storesDone = 0;
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 7; i++) begin
            tick();
            checkOutput($sformatf("burst%0d mem_we", i), mem_we, {31'd0, !loadSlot[i]});
            mem_ready = 1'b1;
            tick();
            checkOutput($sformatf("burst%0d st_done", i), st_done, {31'd0, !loadSlot[i]});
            checkOutput($sformatf("burst%0d ld_done", i), ld_done, {31'd0, loadSlot[i]});
            if (loadSlot[i]) begin
                ld_req = 1'b0;
            end else begin
                storesDone++;
                if (storesDone == 6) st_req = 1'b0;
            end
            mem_ready = 1'b0;
            tick();
        end
        tick();
        checkOutput("burst drained", mem_req, 0);

        // Flush masks fetch in IDLE, then a flushed fetch with three BUSY cycles
        doReset();
        if_addr = 32'h80;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        flush = 1'b1;
        tick();
        checkOutput("flush idle mask", mem_req, 0);
        flush = 1'b0;
        tick();
        checkOutput("fetch busy1 mem_req", mem_req, 1);
        checkOutput("fetch busy1 addr", mem_addr, 32'h80);
        tick();
        checkOutput("fetch busy2 mem_req", mem_req, 1);
        flush  = 1'b1;
        if_req = 1'b0;
        tick();
        checkOutput("fetch busy3 mem_req", mem_req, 1);
        flush     = 1'b0;
        mem_rdata = 32'h33333333;
        mem_ready = 1'b1;
        tick();
        checkOutput("flushed resp if_done", if_done, 0);
        checkOutput("flushed resp mem_req", mem_req, 0);
        ld_addr = 32'h500;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("post flush if_done", if_done, 0);
        tick();
        checkOutput("post flush grant", mem_addr, 32'h500);
        mem_ready = 1'b1;
        tick();
        checkOutput("post flush ld_done", ld_done, 1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick();

        // Masked store with one stall cycle
        st_addr = 32'h600;
        st_data = 32'h12345678;
        st_mask = 4'b0011;
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput($sformatf("st busy%0d we", i), mem_we, 1);
            checkOutput($sformatf("st busy%0d mask", i), mem_mask, 4'b0011);
            checkOutput($sformatf("st busy%0d wdata", i), mem_wdata, 32'h12345678);
        end
        mem_ready = 1'b1;
        tick();
        checkOutput("st resp st_done", st_done, 1);
        checkOutput("st resp mem_we", mem_we, 0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checkOutput("st idle st_done", st_done, 0);

        // Reset in the middle of a load
        ld_addr = 32'h700;
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        tick();
        checkOutput("abort busy mem_req", mem_req, 1);
        rst = 1'b1;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checkOutput("abort mem_req", mem_req, 0);
        checkOutput("abort mem_addr", mem_addr, 0);
        checkOutput("abort ld_done", ld_done, 0);
        rst = 1'b0;
        tick();
        checkOutput("abort after ld_done", ld_done, 0);
        checkOutput("abort after mem_req", mem_req, 0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
